alu_bcd_unit: RTL and testbench
===============================

# alu_bcd_unit

Datapath arithmetic block for the 65xx core: registered A/B operand latches feeding an 8-bit combinational ALU with binary/BCD add and subtract, logic ops and shifts, plus a decimal-adjust stage on the special bus. The ALU result goes back onto the internal busses. The decimal-adjust output feeds the accumulator load path. Opcode selection and control come from the core's microcode sequencer.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears operand latches and carry_last.
- a_in  in  8  ALU A operand; captured into a_reg every clock.
- b_in  in  8  ALU B operand; captured into b_reg only when b_load=1.
- b_load  in  1  B latch enable.
- c_in  in  1  carry input; live, not registered.
- op  in  4  operation: 0 ADC, 1 SBC, 2 OR, 3 AND, 4 EOR, 5 ASL, 6 LSR, 7 ROL, 8 ROR, 9–15 pass A.
- dec_add  in  1  BCD add mode; live.
- dec_sub  in  1  BCD subtract mode; live.
- sb_in  in  8  special-bus value to be decimal-adjusted.
- alu_out  out  8  combinational result.
- carry_out  out  1  combinational carry.
- half_carry_out  out  1  combinational nibble carry.
- overflow_out  out  1  combinational signed overflow.
- carry_last  out  1  carry_out registered on the previous clock.
- a_msb  out  1  a_reg[7]; sign of the last A operand, used for branch offsets.
- decadj_out  out  8  decimal-adjusted sb_in.

## Operation
- ADC and SBC perform the same add: A+B+c_in. For SBC the caller presents ~B; SBC differs from ADC only in the decimal-mode selection below.
- Binary add:
  - L = A[3:0]+B[3:0]+c_in; half_carry_out = L>15.
  - The 9-bit sum gives alu_out and carry_out.
  - overflow_out = ~(A7^B7) & (A7^alu_out7).
- Decimal add (dec_add=1 and op=ADC):
  - half_carry_out = L>9.
  - H = A[7:4]+B[7:4]+half_carry_out; carry_out = H>9.
  - alu_out = {H[3:0], L[3:0]}, unadjusted.
  - overflow_out = ~(A7^B7) & (A7^H[3]).
- Decimal subtract (dec_sub=1 and op=SBC): the ALU behaves exactly as a binary add. Only the adjust stage differs.
- Mode priority:
  - dec_add has priority if both dec_add and dec_sub are set.
  - dec flags are ignored by the ALU for ops other than ADC/SBC.
- Logic ops (OR, AND, EOR): bitwise on A,B; carry_out=0, half_carry_out=0, overflow_out=0.
- Shifts operate on A only:
  - ASL: out={A[6:0],0}, carry=A7.
  - ROL: out={A[6:0],c_in}, carry=A7.
  - LSR: out={0,A[7:1]}, carry=A0.
  - ROR: out={c_in,A[7:1]}, carry=A0.
  - Half carry and overflow are 0 for shifts.
- Pass A (op 9–15): out=A; carry, half carry and overflow are 0.
- Decimal adjust stage: uses the block's current carry_out and half_carry_out. All adds are nibble-wise mod 16, with no carry between nibbles.
  - dec_add: low nibble +6 if half_carry_out=1; high nibble +6 if carry_out=1.
  - dec_sub (and dec_add=0): low nibble −6 if half_carry_out=0; high nibble −6 if carry_out=0.
  - Neither flag set: decadj_out = sb_in.

## Timing
- a_reg is loaded every posedge. b_reg is loaded on posedge only when b_load=1, otherwise it holds.
- carry_last <= carry_out every posedge.
- On reset, a_reg=0, b_reg=0, carry_last=0. The combinational outputs then follow, e.g. op=ADC with c_in=0 gives alu_out=0 and all flags 0.
- Latency: operands presented in cycle N produce alu_out in cycle N+1. c_in, op, dec_add, dec_sub and sb_in act in the same cycle (zero latency).
- Reset asserted mid-operation overrides the load for that edge.

## Test plan
- Binary ADC: A=0x7F, B=0x01, c_in=0 -> out 0x80, C=0, V=1, HC=1. A=0xFF, B=0x01 -> out 0x00, C=1, V=0.
- Decimal ADC: A=0x58, B=0x46, c_in=0, dec_add, sb_in=alu_out -> decadj_out 0x04, C=1. A=0x09, B=0x01 -> 0x10, C=0.
- Decimal SBC: A=0x00, B=~0x01=0xFE, c_in=1, dec_sub -> alu_out 0xFF, decadj_out 0x99, C=0. A=0x10, same B -> decadj_out 0x09, C=1.
- Shifts, A=0x81: ROL c_in=1 -> 0x03, C=1. ROR c_in=0 -> 0x40, C=1. LSR -> 0x40, C=1. ASL -> 0x02, C=1.
- b_load hold: load B=0x0F, then b_in=0xF0 with b_load=0, op AND, A=0xFF -> out 0x0F. Decimal flags off -> decadj_out = sb_in.
- Reset and registered outputs:
  - After reset, alu_out=0 and carry_last=0.
  - A carry generated in cycle N appears on carry_last in cycle N+1.
  - A=0x80 gives a_msb=1 one cycle later.

Source files
------------

// File: rtl/alu_bcd_unit.sv
// 65xx datapath ALU: registered A/B operand latches, 8-bit binary/BCD ALU, decimal-adjust stage.
// Latency: operands captured on posedge drive alu_out the next cycle; c_in/op/dec flags/sb_in act combinationally.
// Backpressure: none; b_load holds the B latch, every other register updates every clock.
module alu_bcd_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    input  logic       b_load,
    input  logic       c_in,
    input  logic [3:0] op,
    input  logic       dec_add,
    input  logic       dec_sub,
    input  logic [7:0] sb_in,
    output logic [7:0] alu_out,
    output logic       carry_out,
    output logic       half_carry_out,
    output logic       overflow_out,
    output logic       carry_last,
    output logic       a_msb,
    output logic [7:0] decadj_out
);

    typedef enum logic [3:0] {
        OP_ADC = 4'd0,
        OP_SBC = 4'd1,
        OP_OR  = 4'd2,
        OP_AND = 4'd3,
        OP_EOR = 4'd4,
        OP_ASL = 4'd5,
        OP_LSR = 4'd6,
        OP_ROL = 4'd7,
        OP_ROR = 4'd8
    } alu_op_e;

    logic [7:0] a_reg_q, a_reg_d;
    logic [7:0] b_reg_q, b_reg_d;
    logic       carry_last_q, carry_last_d;

    logic [4:0] lo_sum;
    logic [4:0] hi_dec;
    logic [8:0] bin_sum;
    logic       dec_hc;
    logic [3:0] lo_adj;
    logic [3:0] hi_adj;

    // Next-state for operand latches and the carry history bit; reset wins over loads.
    always_comb begin
        a_reg_d      = a_in;
        b_reg_d      = b_load ? b_in : b_reg_q;
        carry_last_d = carry_out;
        if (reset) begin
            a_reg_d      = 8'h00;
            b_reg_d      = 8'h00;
            carry_last_d = 1'b0;
        end
    end

    // Register update.
    always_ff @(posedge clk) begin
        a_reg_q      <= a_reg_d;
        b_reg_q      <= b_reg_d;
        carry_last_q <= carry_last_d;
    end

    // ALU: binary add is shared by ADC/SBC (caller inverts B for SBC); only ADC honours BCD.
    always_comb begin
        lo_sum  = {1'b0, a_reg_q[3:0]} + {1'b0, b_reg_q[3:0]} + {4'b0, c_in};
        bin_sum = {1'b0, a_reg_q} + {1'b0, b_reg_q} + {8'b0, c_in};
        dec_hc  = (lo_sum > 5'd9);
        hi_dec  = {1'b0, a_reg_q[7:4]} + {1'b0, b_reg_q[7:4]} + {4'b0, dec_hc};

        alu_out        = a_reg_q;
        carry_out      = 1'b0;
        half_carry_out = 1'b0;
        overflow_out   = 1'b0;

        case (op)
            OP_ADC, OP_SBC: begin
                if (dec_add && (op == OP_ADC)) begin
                    // Unadjusted BCD result; the adjust stage fixes the digits later.
                    alu_out        = {hi_dec[3:0], lo_sum[3:0]};
                    half_carry_out = dec_hc;
                    carry_out      = (hi_dec > 5'd9);
                    overflow_out   = ~(a_reg_q[7] ^ b_reg_q[7]) & (a_reg_q[7] ^ hi_dec[3]);
                end else begin
                    alu_out        = bin_sum[7:0];
                    carry_out      = bin_sum[8];
                    half_carry_out = lo_sum[4];
                    overflow_out   = ~(a_reg_q[7] ^ b_reg_q[7]) & (a_reg_q[7] ^ bin_sum[7]);
                end
            end
            OP_OR:  alu_out = a_reg_q | b_reg_q;
            OP_AND: alu_out = a_reg_q & b_reg_q;
            OP_EOR: alu_out = a_reg_q ^ b_reg_q;
            OP_ASL: begin
                alu_out   = {a_reg_q[6:0], 1'b0};
                carry_out = a_reg_q[7];
            end
            OP_LSR: begin
                alu_out   = {1'b0, a_reg_q[7:1]};
                carry_out = a_reg_q[0];
            end
            OP_ROL: begin
                alu_out   = {a_reg_q[6:0], c_in};
                carry_out = a_reg_q[7];
            end
            OP_ROR: begin
                alu_out   = {c_in, a_reg_q[7:1]};
                carry_out = a_reg_q[0];
            end
            default: alu_out = a_reg_q;
        endcase
    end

    // Decimal adjust of the special bus: nibble-wise +6 after add, -6 after subtract, no inter-nibble carry.
    always_comb begin
        lo_adj = sb_in[3:0];
        hi_adj = sb_in[7:4];
        if (dec_add) begin
            if (half_carry_out) lo_adj = sb_in[3:0] + 4'd6;
            if (carry_out)      hi_adj = sb_in[7:4] + 4'd6;
        end else if (dec_sub) begin
            if (!half_carry_out) lo_adj = sb_in[3:0] - 4'd6;
            if (!carry_out)      hi_adj = sb_in[7:4] - 4'd6;
        end
    end

    assign decadj_out = {hi_adj, lo_adj};
    assign carry_last = carry_last_q;
    assign a_msb      = a_reg_q[7];

endmodule

// File: tb/tb_alu_bcd_unit.sv
// Self-checking bench for alu_bcd_unit: directed cases plus randomized vectors vs. an arithmetic reference model.
// Latency: model tracks operand latches one clock behind inputs; live controls are checked same cycle.
// Backpressure: not applicable.
module tb_alu_bcd_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] a_in = 8'h00;
    logic [7:0] b_in = 8'h00;
    logic       b_load = 1'b0;
    logic       c_in = 1'b0;
    logic [3:0] op = 4'd0;
    logic       dec_add = 1'b0;
    logic       dec_sub = 1'b0;
    logic [7:0] sb_in = 8'h00;
    logic [7:0] alu_out;
    logic       carry_out;
    logic       half_carry_out;
    logic       overflow_out;
    logic       carry_last;
    logic       a_msb;
    logic [7:0] decadj_out;

    int n_vec = 0;
    int n_err = 0;

    // Model state: what the operand latches and carry history should hold.
    int m_a = 0;
    int m_b = 0;
    int m_cl = 0;

    alu_bcd_unit dut (
        .clk            (clk),
        .reset          (reset),
        .a_in           (a_in),
        .b_in           (b_in),
        .b_load         (b_load),
        .c_in           (c_in),
        .op             (op),
        .dec_add        (dec_add),
        .dec_sub        (dec_sub),
        .sb_in          (sb_in),
        .alu_out        (alu_out),
        .carry_out      (carry_out),
        .half_carry_out (half_carry_out),
        .overflow_out   (overflow_out),
        .carry_last     (carry_last),
        .a_msb          (a_msb),
        .decadj_out     (decadj_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h want %02h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model in plain integer arithmetic, decimal digits via /16 and %16.
    task automatic model(input int a, input int b, input int cin, input int opv,
                         input int da, input int ds, input int sb,
                         output int out, output int c, output int hc, output int v, output int adj);
        int lo, hi, s, al, ah;
        out = a; c = 0; hc = 0; v = 0;
        lo = (a % 16) + (b % 16) + cin;
        if (opv == 0 || opv == 1) begin
            if (opv == 0 && da != 0) begin
                hc  = (lo > 9) ? 1 : 0;
                hi  = a / 16 + b / 16 + hc;
                c   = (hi > 9) ? 1 : 0;
                out = (hi % 16) * 16 + lo % 16;
                v   = (((a >= 128) == (b >= 128)) && ((a >= 128) != ((hi % 16) >= 8))) ? 1 : 0;
            end else begin
                s   = a + b + cin;
                out = s % 256;
                c   = (s > 255) ? 1 : 0;
                hc  = (lo > 15) ? 1 : 0;
                v   = (((a >= 128) == (b >= 128)) && ((a >= 128) != (out >= 128))) ? 1 : 0;
            end
        end else if (opv == 2) out = a | b;
        else if (opv == 3) out = a & b;
        else if (opv == 4) out = a ^ b;
        else if (opv == 5) begin out = (a * 2) % 256;           c = a / 128; end
        else if (opv == 6) begin out = a / 2;                   c = a % 2;   end
        else if (opv == 7) begin out = (a * 2) % 256 + cin;     c = a / 128; end
        else if (opv == 8) begin out = a / 2 + 128 * cin;       c = a % 2;   end
        al = sb % 16;
        ah = sb / 16;
        if (da != 0) begin
            if (hc != 0) al = (al + 6) % 16;
            if (c != 0)  ah = (ah + 6) % 16;
        end else if (ds != 0) begin
            if (hc == 0) al = (al + 10) % 16;
            if (c == 0)  ah = (ah + 10) % 16;
        end
        adj = ah * 16 + al;
    endtask

    // One clock: present operands, let the edge capture them, advance the model.
    task automatic step(input int a, input int b, input int bl, input int rst);
        int o, c, h, v, d;
        model(m_a, m_b, int'(c_in), int'(op), int'(dec_add), int'(dec_sub), int'(sb_in), o, c, h, v, d);
        a_in   = a[7:0];
        b_in   = b[7:0];
        b_load = bl[0];
        reset  = rst[0];
        @(posedge clk);
        #1;
        reset  = 1'b0;
        b_load = 1'b0;
        if (rst != 0) begin
            m_a = 0; m_b = 0; m_cl = 0;
        end else begin
            m_a = a % 256;
            if (bl != 0) m_b = b % 256;
            m_cl = c;
        end
    endtask

    // Drive the zero-latency controls; optionally feed the expected ALU result back onto sb_in.
    task automatic live(input int opv, input int cin, input int da, input int ds, input int sb, input int use_out);
        int o, c, h, v, d;
        op      = opv[3:0];
        c_in    = cin[0];
        dec_add = da[0];
        dec_sub = ds[0];
        sb_in   = sb[7:0];
        if (use_out != 0) begin
            model(m_a, m_b, cin, opv, da, ds, 0, o, c, h, v, d);
            sb_in = o[7:0];
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        int o, c, h, v, d;
        model(m_a, m_b, int'(c_in), int'(op), int'(dec_add), int'(dec_sub), int'(sb_in), o, c, h, v, d);
        chk({tag, ".out"}, alu_out, o[7:0]);
        chk({tag, ".c"},   {7'b0, carry_out}, c[7:0]);
        chk({tag, ".hc"},  {7'b0, half_carry_out}, h[7:0]);
        chk({tag, ".v"},   {7'b0, overflow_out}, v[7:0]);
        chk({tag, ".cl"},  {7'b0, carry_last}, m_cl[7:0]);
        chk({tag, ".msb"}, {7'b0, a_msb}, {7'b0, m_a >= 128});
        chk({tag, ".adj"}, decadj_out, d[7:0]);
    endtask

    initial begin
        // Reset: operands cleared, ADC with c_in=0 yields zero everywhere.
        live(0, 0, 0, 0, 0, 0);
        step(8'hA5, 8'h5A, 1, 1);
        check_all("reset");
        chk("reset.out_lit", alu_out, 8'h00);
        chk("reset.cl_lit", {7'b0, carry_last}, 8'h00);

        // Binary ADC.
        step(8'h7F, 8'h01, 1, 0);
        live(0, 0, 0, 0, 0, 0);
        check_all("adc7f");
        chk("adc7f.out_lit", alu_out, 8'h80);
        chk("adc7f.v_lit", {7'b0, overflow_out}, 8'h01);
        chk("adc7f.hc_lit", {7'b0, half_carry_out}, 8'h01);
        step(8'hFF, 8'h01, 1, 0);
        check_all("adcff");
        chk("adcff.out_lit", alu_out, 8'h00);
        chk("adcff.c_lit", {7'b0, carry_out}, 8'h01);
        // Carry from the previous cycle shows up on carry_last.
        step(8'h12, 8'h01, 1, 0);
        chk("cl_follow_lit", {7'b0, carry_last}, 8'h01);
        check_all("clfollow");

        // Decimal ADC with sb_in = ALU result.
        step(8'h58, 8'h46, 1, 0);
        live(0, 0, 1, 0, 0, 1);
        check_all("dadd58");
        chk("dadd58.adj_lit", decadj_out, 8'h04);
        chk("dadd58.c_lit", {7'b0, carry_out}, 8'h01);
        step(8'h09, 8'h01, 1, 0);
        live(0, 0, 1, 0, 0, 1);
        check_all("dadd09");
        chk("dadd09.adj_lit", decadj_out, 8'h10);
        chk("dadd09.c_lit", {7'b0, carry_out}, 8'h00);

        // Decimal SBC with inverted B.
        step(8'h00, 8'hFE, 1, 0);
        live(1, 1, 0, 1, 0, 1);
        check_all("dsub00");
        chk("dsub00.out_lit", alu_out, 8'hFF);
        chk("dsub00.adj_lit", decadj_out, 8'h99);
        chk("dsub00.c_lit", {7'b0, carry_out}, 8'h00);
        step(8'h10, 8'hFE, 1, 0);
        live(1, 1, 0, 1, 0, 1);
        check_all("dsub10");
        chk("dsub10.adj_lit", decadj_out, 8'h09);
        chk("dsub10.c_lit", {7'b0, carry_out}, 8'h01);

        // Shifts on A=0x81.
        step(8'h81, 8'h00, 0, 0);
        chk("msb81_lit", {7'b0, a_msb}, 8'h01);
        live(7, 1, 0, 0, 0, 0); check_all("rol"); chk("rol.out_lit", alu_out, 8'h03);
        live(8, 0, 0, 0, 0, 0); check_all("ror"); chk("ror.out_lit", alu_out, 8'h40);
        live(6, 0, 0, 0, 0, 0); check_all("lsr"); chk("lsr.out_lit", alu_out, 8'h40);
        live(5, 0, 0, 0, 0, 0); check_all("asl"); chk("asl.out_lit", alu_out, 8'h02);
        chk("asl.c_lit", {7'b0, carry_out}, 8'h01);

        // B latch holds when b_load is low; decimal flags off pass sb_in through.
        step(8'h00, 8'h0F, 1, 0);
        step(8'hFF, 8'hF0, 0, 0);
        live(3, 0, 0, 0, 8'h5A, 0);
        check_all("bhold");
        chk("bhold.out_lit", alu_out, 8'h0F);
        chk("bhold.adj_lit", decadj_out, 8'h5A);

        // Randomized vectors, including both-decimal-flags and mid-stream resets.
        for (int i = 0; i < 400; i++) begin
            step(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0) ? 1 : 0);
            live(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0) ? 1 : 0, ($urandom_range(0, 2) == 0) ? 1 : 0,
                 int'($urandom_range(0, 255)), ($urandom_range(0, 1) == 0) ? 1 : 0);
            check_all("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
